// File: rtl/game_status_ctrl.sv
// Game-flow controller: debounces the start key, sequences START -> PLAY -> END -> START
// as a one-hot screen select, and pulses play_init on the first PLAY cycle of each game.
module game_status_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 800000,
  parameter int unsigned END_HOLD_CYCLES = 80000000
) (
  input  logic       Clk_40mhz,
  input  logic       RSTn,
  input  logic       key_start,
  input  logic       collide,
  output logic [2:0] Game_status,
  output logic       play_init
);

  localparam logic [2:0] ST_START = 3'b001;
  localparam logic [2:0] ST_PLAY  = 3'b010;
  localparam logic [2:0] ST_END   = 3'b100;

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HW = $clog2(END_HOLD_CYCLES + 1);

  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(END_HOLD_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic          r_deb_d;
  logic [DW-1:0] r_deb_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic [2:0]    r_status;
  logic          r_play_init;

  logic          w_press;
  logic [2:0]    w_status_nxt;
  logic          w_play_init_nxt;
  logic [HW-1:0] w_hold_nxt;

  // Released level is 1, so the synchronizer resets to 1 to avoid a false press at reset exit.
  always_ff @(posedge Clk_40mhz or negedge RSTn) begin
    if (!RSTn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_start;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge Clk_40mhz or negedge RSTn) begin
    if (!RSTn) begin
      r_deb     <= 1'b1;
      r_deb_cnt <= '0;
    end else if (r_sync2 != r_deb) begin
      if (r_deb_cnt == DEB_MAX) begin
        r_deb     <= r_sync2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
    end else begin
      r_deb_cnt <= '0;
    end
  end

  always_ff @(posedge Clk_40mhz or negedge RSTn) begin
    if (!RSTn) begin
      r_deb_d <= 1'b1;
    end else begin
      r_deb_d <= r_deb;
    end
  end

  // One event per debounced 1->0 transition; a held key stays low and never re-fires.
  assign w_press = r_deb_d & ~r_deb;

  always_comb begin
    w_status_nxt    = r_status;
    w_play_init_nxt = 1'b0;
    w_hold_nxt      = r_hold_cnt;
    case (r_status)
      ST_START: begin
        if (w_press) begin
          w_status_nxt    = ST_PLAY;
          w_play_init_nxt = 1'b1;
        end
      end
      ST_PLAY: begin
        if (collide) begin
          w_status_nxt = ST_END;
          w_hold_nxt   = HOLD_LOAD;
        end
      end
      ST_END: begin
        // Presses during the dwell are dropped, not remembered for later.
        if (r_hold_cnt != '0) begin
          w_hold_nxt = r_hold_cnt - HW'(1);
        end else if (w_press) begin
          w_status_nxt = ST_START;
        end
      end
      default: begin
        w_status_nxt = ST_START;
      end
    endcase
  end

  always_ff @(posedge Clk_40mhz or negedge RSTn) begin
    if (!RSTn) begin
      r_status    <= ST_START;
      r_play_init <= 1'b0;
      r_hold_cnt  <= '0;
    end else begin
      r_status    <= w_status_nxt;
      r_play_init <= w_play_init_nxt;
      r_hold_cnt  <= w_hold_nxt;
    end
  end

  assign Game_status = r_status;
  assign play_init   = r_play_init;

endmodule

// File: doc/game_status_ctrl.md
# game_status_ctrl

Game-flow controller that produces the one-hot `Game_status` vector consumed by the VGA screen selector, which shows the start, play or end screen. It debounces the raw start pushbutton and tracks collision reports from the snake play logic. It sequences START → PLAY → END → START and emits a one-cycle init pulse so the play logic restarts cleanly on every new game. It sits at top level beside the screen selector, in the `Clk_40mhz` domain.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 800000 — consecutive stable cycles required to accept a key level change (20 ms at 40 MHz); must be ≥ 2.
- `END_HOLD_CYCLES`, default 80000000 — minimum END dwell (2 s) before a restart press is honoured; must be ≥ 1.

Ports:
- `Clk_40mhz` in 1 — system clock; the only clock.
- `RSTn` in 1 — reset, asynchronous, active-low.
- `key_start` in 1 — raw start pushbutton, active-low (0 = pressed), asynchronous to `Clk_40mhz`, bouncy.
- `collide` in 1 — collision report from play logic, synchronous, active-high, level or pulse.
- `Game_status` out 3 — one-hot: START 3'b001, PLAY 3'b010, END 3'b100; registered.
- `play_init` out 1 — one-cycle pulse in the first cycle `Game_status` = PLAY; registered.

## Operation
- Synchronizer: two flops on `key_start`. Both flops reset to 1 (released).
- Debouncer:
  - Counter width is ceil(log2(DEBOUNCE_CYCLES)).
  - Debounced level `deb` resets to 1.
  - Each edge where sync output ≠ `deb`: counter increments. When the counter equals DEBOUNCE_CYCLES-1, `deb` takes the sync value and the counter clears.
  - Each edge where sync output = `deb`: counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are fully rejected.
- Press event: `press` = `deb_d` & ~`deb`, where `deb_d` is `deb` delayed one cycle, reset to 1. This yields one pulse per debounced 1→0 transition. A held key never re-triggers.
- FSM, states START / PLAY / END, encoded directly as `Game_status`:
  - START: `press` → PLAY, and `play_init` is set to 1 for that first PLAY cycle. `collide` is ignored.
  - PLAY: `collide` = 1 → END, with the hold counter loaded to END_HOLD_CYCLES. `press` is ignored. If `collide` and `press` occur together, `collide` wins.
  - END: the hold counter decrements each cycle until it reaches 0 and saturates there. `press` while the counter ≠ 0 is discarded, not queued. `press` with the counter = 0 → START. `collide` is ignored.
  - Any non-one-hot `Game_status` value → START on the next edge; `play_init` stays 0.
- `play_init` is 0 in every cycle except the first PLAY cycle.
- Hold counter width is ceil(log2(END_HOLD_CYCLES+1)). It resets to 0 and is only loaded on PLAY→END.

## Timing
- Reset values: `Game_status` = 3'b001, `play_init` = 0, sync flops = 1, `deb` = `deb_d` = 1, all counters 0. Assertion of `RSTn` mid-game forces these values immediately (asynchronous). Deassertion resumes in START.
- Key-to-status latency: with `key_start` held low from the edge that first samples it low (edge 1), `Game_status` changes at edge DEBOUNCE_CYCLES+3. `play_init` is high for exactly that one following cycle.
- Collide latency: `collide` = 1 sampled at edge k in PLAY → `Game_status` = 3'b100 after edge k.
- END dwell: entering END at edge k, the earliest edge that can accept `press` is k+END_HOLD_CYCLES+1.
- Release latency: the 0→1 `deb` transition also takes DEBOUNCE_CYCLES, but it generates no event.

## Test plan
Run all scenarios with DEBOUNCE_CYCLES=4 and END_HOLD_CYCLES=10.
- Reset, then idle for 50 cycles → `Game_status` = 001 throughout and `play_init` = 0.
- Hold `key_start` = 0 from edge 1 → `Game_status` = 010 after edge 7. `play_init` = 1 for exactly one cycle. Holding the key another 100 cycles gives no further change.
- Bounce: in START, drive `key_start` low for 3 cycles, high for 1, low for 3, repeated 5 times, then high → stays 001. Then a clean 10-cycle press → 010.
- In PLAY, pulse `collide` for 1 cycle at edge k together with a debounced press → 100 after edge k, and the press has no effect. Press again at k+5 (debounced) → stays 100. A press accepted at or after k+11 → 001, with `play_init` = 0.
- Drive `collide` = 1 continuously in START and END → no state change. Then pulse `RSTn` low for 2 cycles mid-PLAY → 001 asynchronously and `play_init` = 0. After release, a press → 010.
- Force `Game_status` to 3'b011 (or 3'b000) → 001 on the next edge with `play_init` = 0.
